// File: rtl/word_serializer_10bit.sv
// word_serializer_10bit: parallel word in (valid/ready), one bit per beat out with first/last markers.
// Optional WORD_SERIALIZER_PARITY_EN appends an even-parity beat after the data bits.
module word_serializer_10bit #(
   parameter int WIDTH     = 10,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             ser_ready,
   output logic             ser_valid,
   output logic             ser_out,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 2);
`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int BEATS = WIDTH + 1;
`else
   localparam int BEATS = WIDTH;
`endif
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             run, data_bit, bit_out;
   assign data_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
`ifdef WORD_SERIALIZER_PARITY_EN
   logic par;
   assign bit_out = (cnt == CW'(WIDTH)) ? par : data_bit;
   always_ff @(posedge clk)
      if (rst) par <= 1'b0;
      else if (state == IDLE && in_valid) par <= ^in_data;
`else
   assign bit_out = data_bit;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sreg  <= in_data;
               cnt   <= '0;
               state <= SHIFT;
            end
            SHIFT: if (ser_ready) begin
               sreg <= MSB_FIRST ? sreg << 1 : sreg >> 1;
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(BEATS - 1)) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   // outputs are gated by rst so everything reads 0 while reset is held
   assign run       = (state == SHIFT) && !rst;
   assign in_ready  = (state == IDLE) && !rst;
   assign done      = (state == DONE) && !rst;
   assign ser_valid = run;
   assign busy      = run;
   assign ser_out   = run && bit_out;
   assign ser_first = run && (cnt == '0);
   assign ser_last  = run && (cnt == CW'(BEATS - 1));
endmodule
